// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: drives the ROM address port, captures the 1-cycle-latency
// ROM reply into a small prefetch FIFO and presents it to the decoder (valid/ready).
module instr_fetch_queue #(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned DEPTH    = 4,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic [WIDTH-1:0] rom_address,
   input  logic [WIDTH-1:0] rom_data,
   input  logic             redirect_valid,
   input  logic [WIDTH-1:0] redirect_target,
   output logic             instr_valid,
   input  logic             instr_ready,
   output logic [WIDTH-1:0] instr_data,
   output logic [WIDTH-1:0] instr_pc
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] r_fetch_pc;
   logic             r_req_q;
   logic [WIDTH-1:0] r_pc_q;
   logic [CNT_W-1:0] r_count;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [WIDTH-1:0] r_mem_data [DEPTH];
   logic [WIDTH-1:0] r_mem_pc   [DEPTH];

   logic [CNT_W-1:0] w_inflight;
   logic             w_issue;
   logic             w_push;
   logic             w_pop;
   logic [CNT_W-1:0] w_count_next;

   // Credit counts the word already in flight so a full FIFO can never be overrun.
   assign w_inflight = r_count + CNT_W'(r_req_q);
   assign w_issue    = !redirect_valid && (w_inflight < CNT_W'(DEPTH));
   assign w_push     = r_req_q && !redirect_valid;
   assign w_pop      = instr_valid && instr_ready;

   always_comb begin
      w_count_next = r_count;
      if (w_push && !w_pop) begin
         w_count_next = r_count + CNT_W'(1);
      end else if (!w_push && w_pop) begin
         w_count_next = r_count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fetch_pc <= RESET_PC;
         r_req_q    <= 1'b0;
         r_pc_q     <= '0;
      end else if (redirect_valid) begin
         r_fetch_pc <= redirect_target;
         r_req_q    <= 1'b0;
      end else if (w_issue) begin
         r_fetch_pc <= r_fetch_pc + WIDTH'(1);
         r_req_q    <= 1'b1;
         r_pc_q     <= r_fetch_pc;
      end else begin
         r_req_q    <= 1'b0;
      end
   end

   // A redirect flushes everything, including a pop accepted in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count  <= '0;
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
      end else if (redirect_valid) begin
         r_count  <= '0;
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
      end else begin
         r_count <= w_count_next;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem_data[i] <= '0;
            r_mem_pc[i]   <= '0;
         end
      end else if (w_push) begin
         r_mem_data[r_wr_ptr] <= rom_data;
         r_mem_pc[r_wr_ptr]   <= r_pc_q;
      end
   end

   assign rom_address = r_fetch_pc;
   assign instr_valid = (r_count != '0);
   assign instr_data  = r_mem_data[r_rd_ptr];
   assign instr_pc    = r_mem_pc[r_rd_ptr];

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(w_push && (r_count == CNT_W'(DEPTH))));

endmodule
